// File: rtl/stream_xor_decrypt.sv
// Byte-stream LFSR XOR decryptor: XORs each accepted ciphertext byte with a Galois keystream.
// Latency: one cycle from input accept to out_valid; full rate when the consumer is always ready.
// Backpressure: in_ready drops while an undrained byte is held. Optional parity: STREAM_XOR_DECRYPT_PARITY_EN.
module stream_xor_decrypt #(
  parameter int                DATA_W = 8,
  parameter int                LFSR_W = 16,
  parameter logic [LFSR_W-1:0] TAPS   = 16'hB400
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              key_load,
  input  logic [LFSR_W-1:0] key,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
`ifdef STREAM_XOR_DECRYPT_PARITY_EN
  input  logic              in_par,
  output logic              par_err,
`endif
  output logic              in_ready,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              key_err
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t            state_q, state_d;
  logic [LFSR_W-1:0] lfsr_q, lfsr_d;
  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              key_err_q, key_err_d;
  logic              accept;
  logic              par_ok;
`ifdef STREAM_XOR_DECRYPT_PARITY_EN
  logic              par_err_q, par_err_d;
`endif

  // Advance the keystream by one byte: eight Galois steps in a single cycle.
  function automatic logic [LFSR_W-1:0] step8(input logic [LFSR_W-1:0] s);
    logic [LFSR_W-1:0] r;
    r = s;
    for (int i = 0; i < 8; i++) begin
      if (r[0]) r = (r >> 1) ^ TAPS;
      else      r = r >> 1;
    end
    return r;
  endfunction

  // Accept only in RUN with the output slot empty or draining this cycle.
  assign in_ready = (state_q == RUN) && (!out_valid_q || out_ready);
  // key_load wins over the input handshake in the same cycle.
  assign accept   = in_valid && in_ready && !key_load;

`ifdef STREAM_XOR_DECRYPT_PARITY_EN
  // Even parity: the parity bit makes the total count of ones even.
  assign par_ok = ((^in_data) == in_par);
`else
  assign par_ok = 1'b1;
`endif

  // Next-state: key handling first, then drain and accept.
  always_comb begin
    state_d     = state_q;
    lfsr_d      = lfsr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    key_err_d   = key_err_q;
`ifdef STREAM_XOR_DECRYPT_PARITY_EN
    par_err_d   = par_err_q;
`endif
    if (key_load) begin
      out_valid_d = 1'b0;
      if (key == '0) begin
        // A zero seed would lock the LFSR at zero; refuse it and flush.
        key_err_d  = 1'b1;
        state_d    = IDLE;
        out_data_d = '0;
      end else begin
        lfsr_d    = key;
        key_err_d = 1'b0;
        state_d   = RUN;
`ifdef STREAM_XOR_DECRYPT_PARITY_EN
        par_err_d = 1'b0;
`endif
      end
    end else begin
      if (out_valid_q && out_ready) out_valid_d = 1'b0;
      if (accept) begin
        // Keystream always advances so it stays aligned with the encryptor.
        lfsr_d = step8(lfsr_q);
        if (par_ok) begin
          out_data_d  = in_data ^ lfsr_q[DATA_W-1:0];
          out_valid_d = 1'b1;
        end else begin
`ifdef STREAM_XOR_DECRYPT_PARITY_EN
          par_err_d = 1'b1;
`endif
        end
      end
    end
  end

  // State registers with synchronous clear.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q     <= IDLE;
      lfsr_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      key_err_q   <= 1'b0;
`ifdef STREAM_XOR_DECRYPT_PARITY_EN
      par_err_q   <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      key_err_q   <= key_err_d;
`ifdef STREAM_XOR_DECRYPT_PARITY_EN
      par_err_q   <= par_err_d;
`endif
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign key_err   = key_err_q;
`ifdef STREAM_XOR_DECRYPT_PARITY_EN
  assign par_err   = par_err_q;
`endif

endmodule

// File: tb/tb_stream_xor_decrypt.sv
// Directed bench for stream_xor_decrypt with hand-computed keystream values.
// Key 16'hACE1 gives keystream bytes E1, C4; LFSR is 16'hC2C4 after one byte.
// Inputs are driven 1 time unit after the rising edge and outputs checked there.
module tb_stream_xor_decrypt;

  logic        clk = 1'b0;
  logic        clear, key_load, in_valid, out_ready;
  logic [15:0] key;
  logic [7:0]  in_data;
  logic        in_ready, out_valid, key_err;
  logic [7:0]  out_data;
`ifdef STREAM_XOR_DECRYPT_PARITY_EN
  logic        in_par, par_err;
`endif

  int vecs = 0;
  int errs = 0;

  always #5 clk = ~clk;

  stream_xor_decrypt dut (
    .clk       (clk),
    .clear     (clear),
    .key_load  (key_load),
    .key       (key),
    .in_valid  (in_valid),
    .in_data   (in_data),
`ifdef STREAM_XOR_DECRYPT_PARITY_EN
    .in_par    (in_par),
    .par_err   (par_err),
`endif
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_data  (out_data),
    .out_ready (out_ready),
    .key_err   (key_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp)
    else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    clear = 1'b1; key_load = 1'b0; key = '0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
`ifdef STREAM_XOR_DECRYPT_PARITY_EN
    in_par = 1'b0;
`endif
    tick(); tick();
    clear = 1'b0;
    #1;
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_key_err", key_err, 0);

    // Basic decrypt of two zero bytes.
    key_load = 1'b1; key = 16'hACE1;
    tick();
    key_load = 1'b0;
    chk("key_in_ready", in_ready, 1);
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    chk("b1_valid", out_valid, 1);
    chk("b1_data", out_data, 8'hE1);
    chk("b1_lfsr", dut.lfsr_q, 16'hC2C4);
    tick();
    chk("b2_data", out_data, 8'hC4);
    in_valid = 1'b0;
    tick();
    chk("b2_drained", out_valid, 0);

    // Output hold under backpressure.
    key_load = 1'b1; key = 16'hACE1;
    tick();
    key_load = 1'b0;
    in_valid = 1'b1; in_data = 8'h5A; out_ready = 1'b0;
    tick();
    in_data = 8'h00;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_valid", out_valid, 1);
      chk("hold_data", out_data, 8'hBB);
      chk("hold_in_ready", in_ready, 0);
      tick();
    end
    out_ready = 1'b1;
    #1;
    chk("drain_in_ready", in_ready, 1);
    tick();
    chk("hold_next_valid", out_valid, 1);
    chk("hold_next_data", out_data, 8'hC4);
    in_valid = 1'b0;
    tick();
    chk("hold_next_drained", out_valid, 0);

    // Zero key rejected, then recovery.
    key_load = 1'b1; key = 16'h0000;
    tick();
    key_load = 1'b0;
    chk("zk_key_err", key_err, 1);
    chk("zk_in_ready", in_ready, 0);
    chk("zk_out_valid", out_valid, 0);
    in_valid = 1'b1; in_data = 8'h11;
    tick();
    chk("zk_no_accept", out_valid, 0);
    in_valid = 1'b0;
    key_load = 1'b1; key = 16'hACE1;
    tick();
    key_load = 1'b0;
    chk("rk_key_err", key_err, 0);
    chk("rk_in_ready", in_ready, 1);

    // Mid-stream rekey with a simultaneous input byte.
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    chk("ms_first", out_data, 8'hE1);
    key_load = 1'b1; key = 16'hACE1; in_data = 8'h33;
    tick();
    key_load = 1'b0;
    chk("ms_flushed", out_valid, 0);
    in_data = 8'h00;
    tick();
    chk("ms_after_valid", out_valid, 1);
    chk("ms_after_data", out_data, 8'hE1);
    in_valid = 1'b0;

    // Clear while a byte is pending.
    out_ready = 1'b0;
    clear = 1'b1;
    tick();
    clear = 1'b0;
    out_ready = 1'b1;
    #1;
    chk("clr_out_valid", out_valid, 0);
    chk("clr_out_data", out_data, 0);
    chk("clr_key_err", key_err, 0);
    chk("clr_in_ready", in_ready, 0);
    in_valid = 1'b1; in_data = 8'h00;
    tick();
    chk("clr_no_accept", out_valid, 0);
    in_valid = 1'b0;

`ifdef STREAM_XOR_DECRYPT_PARITY_EN
    // Bad parity byte is dropped but still advances the keystream.
    key_load = 1'b1; key = 16'hACE1;
    tick();
    key_load = 1'b0;
    in_valid = 1'b1; in_data = 8'h01; in_par = 1'b0;
    tick();
    chk("par_drop", out_valid, 0);
    chk("par_err", par_err, 1);
    in_data = 8'h00; in_par = 1'b0;
    tick();
    chk("par_next_valid", out_valid, 1);
    chk("par_next_data", out_data, 8'hC4);
    in_valid = 1'b0;
    key_load = 1'b1; key = 16'hACE1;
    tick();
    key_load = 1'b0;
    chk("par_err_cleared", par_err, 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
